// File: rtl/cuckoo_kv_engine.sv
// rtl/cuckoo_kv_engine.sv - two-table cuckoo-hash balance store with bounded-kick insert and one-entry stash
module cuckoo_kv_engine #(
   parameter int KEY_WIDTH = 32,
   parameter int VAL_WIDTH = 32,
   parameter int ADDR_BITS = 4,
   parameter int MAX_KICKS = 11
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [KEY_WIDTH-1:0] req_key,
   input  logic [VAL_WIDTH-1:0] req_value,
   output logic                 resp_valid,
   output logic [2:0]           resp_status,
   output logic [VAL_WIDTH-1:0] resp_value,
   output logic [ADDR_BITS+1:0] count
);
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam int KW    = $clog2(MAX_KICKS + 1);
   localparam logic [1:0] OP_SEARCH = 2'd0, OP_CREDIT = 2'd2, OP_DEBIT = 2'd3;
   localparam logic [2:0] ST_OK = 3'd0, ST_NOT_FOUND = 3'd1, ST_DUPLICATE = 3'd2, ST_FULL = 3'd3,
                          ST_UNDERFLOW = 3'd4, ST_OVERFLOW = 3'd5, ST_BAD_KEY = 3'd6;
   localparam logic [ADDR_BITS+1:0] CNT_ONE  = 1;
   localparam logic [ADDR_BITS-1:0] IDX_ONE  = 1;
   localparam logic [KW-1:0]        KICK_ONE = 1;
   localparam logic [KW-1:0]        KICK_MAX = KW'(MAX_KICKS);

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_KICK1, S_KICK2, S_RESP} state_t;

   state_t state, state_n;
   logic [KEY_WIDTH-1:0] t1_key [DEPTH];
   logic [VAL_WIDTH-1:0] t1_val [DEPTH];
   logic [KEY_WIDTH-1:0] t2_key [DEPTH];
   logic [VAL_WIDTH-1:0] t2_val [DEPTH];

   logic [ADDR_BITS-1:0] clr_idx, clr_idx_n;
   logic [1:0]           op_q, op_n;
   logic [KEY_WIDTH-1:0] key_q, key_n, carry_key, carry_key_n, stash_key, stash_key_n;
   logic [VAL_WIDTH-1:0] val_q, val_n, carry_val, carry_val_n, stash_val, stash_val_n;
   logic [KW-1:0]        kicks, kicks_n;
   logic                 stash_v, stash_v_n, ready_n, resp_valid_n;
   logic [2:0]           resp_status_n;
   logic [VAL_WIDTH-1:0] resp_value_n;
   logic [ADDR_BITS+1:0] count_n;

   logic                 t1_we, t2_we, wb_en, done_ok, do_spill;
   logic [ADDR_BITS-1:0] t1_addr, t2_addr;
   logic [KEY_WIDTH-1:0] t1_wkey, t2_wkey;
   logic [VAL_WIDTH-1:0] t1_wval, t2_wval, wb_val, hit_val;
   logic [ADDR_BITS-1:0] lk_a1, lk_a2, k_a1, k_a2;
   logic                 hit1, hit2, hit_s, hit;
   logic [VAL_WIDTH:0]   sum;

   assign lk_a1   = key_q[ADDR_BITS-1:0];
   assign lk_a2   = key_q[2*ADDR_BITS-1:ADDR_BITS] ^ key_q[ADDR_BITS-1:0];
   assign k_a1    = carry_key[ADDR_BITS-1:0];
   assign k_a2    = carry_key[2*ADDR_BITS-1:ADDR_BITS] ^ carry_key[ADDR_BITS-1:0];
   assign hit1    = (t1_key[lk_a1] == key_q);
   assign hit2    = (t2_key[lk_a2] == key_q);
   assign hit_s   = stash_v && (stash_key == key_q);
   assign hit     = hit1 || hit2 || hit_s;
   assign hit_val = hit1 ? t1_val[lk_a1] : (hit2 ? t2_val[lk_a2] : stash_val);
   assign sum     = {1'b0, hit_val} + {1'b0, val_q};

   always_comb begin
      state_n = state;  clr_idx_n = clr_idx;
      op_n = op_q;  key_n = key_q;  val_n = val_q;
      carry_key_n = carry_key;  carry_val_n = carry_val;  kicks_n = kicks;
      stash_v_n = stash_v;  stash_key_n = stash_key;  stash_val_n = stash_val;
      count_n = count;  ready_n = 1'b0;  resp_valid_n = 1'b0;
      resp_status_n = resp_status;  resp_value_n = resp_value;
      t1_we = 1'b0;  t1_addr = lk_a1;  t1_wkey = key_q;  t1_wval = val_q;
      t2_we = 1'b0;  t2_addr = lk_a2;  t2_wkey = key_q;  t2_wval = val_q;
      wb_en = 1'b0;  wb_val = '0;  done_ok = 1'b0;  do_spill = 1'b0;
      case (state)
         S_CLEAR: begin
            t1_we = 1'b1;  t1_addr = clr_idx;  t1_wkey = '0;  t1_wval = '0;
            t2_we = 1'b1;  t2_addr = clr_idx;  t2_wkey = '0;  t2_wval = '0;
            clr_idx_n = clr_idx + IDX_ONE;
            if (&clr_idx) begin
               state_n = S_IDLE;
               ready_n = 1'b1;
            end
         end
         S_IDLE: begin
            ready_n = 1'b1;
            if (req_valid && req_ready) begin
               op_n = req_op;  key_n = req_key;  val_n = req_value;
               state_n = S_LOOKUP;
               ready_n = 1'b0;
            end
         end
         S_LOOKUP: begin
            state_n = S_RESP;  resp_valid_n = 1'b1;  resp_value_n = '0;
            if (key_q == '0) resp_status_n = ST_BAD_KEY;
            else if (op_q == OP_SEARCH) begin
               resp_status_n = hit ? ST_OK : ST_NOT_FOUND;
               if (hit) resp_value_n = hit_val;
            end else if (op_q == OP_CREDIT || op_q == OP_DEBIT) begin
               if (!hit) resp_status_n = ST_NOT_FOUND;
               else if (op_q == OP_CREDIT && sum[VAL_WIDTH]) resp_status_n = ST_OVERFLOW;
               else if (op_q == OP_DEBIT && val_q > hit_val) resp_status_n = ST_UNDERFLOW;
               else begin
                  wb_en = 1'b1;
                  wb_val = (op_q == OP_CREDIT) ? sum[VAL_WIDTH-1:0] : hit_val - val_q;
                  resp_status_n = ST_OK;
                  resp_value_n = wb_val;
               end
            end else if (hit) resp_status_n = ST_DUPLICATE;
            else if (stash_v) resp_status_n = ST_FULL;
            else if (t1_key[lk_a1] == '0) begin
               t1_we = 1'b1;
               done_ok = 1'b1;
            end else begin
               carry_key_n = key_q;  carry_val_n = val_q;  kicks_n = '0;
               state_n = S_KICK1;  resp_valid_n = 1'b0;  resp_value_n = resp_value;
            end
            // balance updates land in whichever of the three locations matched
            if (wb_en) begin
               if (hit1) begin t1_we = 1'b1;  t1_wval = wb_val; end
               else if (hit2) begin t2_we = 1'b1;  t2_wval = wb_val; end
               else stash_val_n = wb_val;
            end
         end
         S_KICK1: begin
            t1_we = 1'b1;  t1_addr = k_a1;  t1_wkey = carry_key;  t1_wval = carry_val;
            kicks_n = kicks + KICK_ONE;
            if (t1_key[k_a1] == '0) done_ok = 1'b1;
            else begin
               carry_key_n = t1_key[k_a1];  carry_val_n = t1_val[k_a1];
               if (kicks_n == KICK_MAX) do_spill = 1'b1;
               else state_n = S_KICK2;
            end
         end
         S_KICK2: begin
            t2_we = 1'b1;  t2_addr = k_a2;  t2_wkey = carry_key;  t2_wval = carry_val;
            if (t2_key[k_a2] == '0) done_ok = 1'b1;
            else begin
               kicks_n = kicks + KICK_ONE;
               carry_key_n = t2_key[k_a2];  carry_val_n = t2_val[k_a2];
               if (kicks_n == KICK_MAX) do_spill = 1'b1;
               else state_n = S_KICK1;
            end
         end
         S_RESP: begin
            state_n = S_IDLE;
            ready_n = 1'b1;
         end
         default: state_n = S_CLEAR;
      endcase
      if (done_ok) begin
         count_n = count + CNT_ONE;
         state_n = S_RESP;  resp_valid_n = 1'b1;
         resp_status_n = ST_OK;  resp_value_n = val_q;
      end
      // the last evicted entry is parked rather than dropped
      if (do_spill) begin
         stash_v_n = 1'b1;  stash_key_n = carry_key_n;  stash_val_n = carry_val_n;
         count_n = count + CNT_ONE;
         state_n = S_RESP;  resp_valid_n = 1'b1;
         resp_status_n = ST_FULL;  resp_value_n = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (t1_we) begin
         t1_key[t1_addr] <= t1_wkey;
         t1_val[t1_addr] <= t1_wval;
      end
      if (t2_we) begin
         t2_key[t2_addr] <= t2_wkey;
         t2_val[t2_addr] <= t2_wval;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_CLEAR;  clr_idx <= '0;
         op_q <= '0;  key_q <= '0;  val_q <= '0;
         carry_key <= '0;  carry_val <= '0;  kicks <= '0;
         stash_v <= 1'b0;  stash_key <= '0;  stash_val <= '0;
         count <= '0;  req_ready <= 1'b0;  resp_valid <= 1'b0;
         resp_status <= '0;  resp_value <= '0;
      end else begin
         state <= state_n;  clr_idx <= clr_idx_n;
         op_q <= op_n;  key_q <= key_n;  val_q <= val_n;
         carry_key <= carry_key_n;  carry_val <= carry_val_n;  kicks <= kicks_n;
         stash_v <= stash_v_n;  stash_key <= stash_key_n;  stash_val <= stash_val_n;
         count <= count_n;  req_ready <= ready_n;  resp_valid <= resp_valid_n;
         resp_status <= resp_status_n;  resp_value <= resp_value_n;
      end
   end
endmodule

// File: tb/tb_cuckoo_kv_engine.sv
// tb/tb_cuckoo_kv_engine.sv - scoreboard bench for cuckoo_kv_engine
module tb_cuckoo_kv_engine;
   localparam logic [1:0] SRCH = 2'd0, INS = 2'd1, CRED = 2'd2, DEB = 2'd3;
   localparam logic [2:0] OK = 3'd0, NF = 3'd1, DUP = 3'd2, FULL = 3'd3,
                          UNDER = 3'd4, OVER = 3'd5, BADK = 3'd6;

   logic        clock = 1'b0;
   logic        reset_n, req_valid, req_ready, resp_valid;
   logic [1:0]  req_op;
   logic [31:0] req_key, req_value, resp_value;
   logic [2:0]  resp_status;
   logic [5:0]  count;

   always #5 clock = ~clock;

   cuckoo_kv_engine #(.KEY_WIDTH(32), .VAL_WIDTH(32), .ADDR_BITS(4), .MAX_KICKS(11)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_key(req_key), .req_value(req_value), .resp_valid(resp_valid),
      .resp_status(resp_status), .resp_value(resp_value), .count(count));

   typedef struct {
      string       nm;
      logic [2:0]  st;
      logic [31:0] val;
      logic [5:0]  cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   resp_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n === 1'b1 && resp_valid === 1'b1) begin
         resp_seen++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=status %0d required=no response", resp_status);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.nm, "_status"}, 64'(resp_status), 64'(mon_e.st));
            check({mon_e.nm, "_value"}, 64'(resp_value), 64'(mon_e.val));
            check({mon_e.nm, "_count"}, 64'(count), 64'(mon_e.cnt));
         end
      end
   end

   task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] k,
                         input logic [31:0] v, input logic [2:0] st, input logic [31:0] rv,
                         input logic [5:0] cnt, input int lat);
      bit acc = 0;
      int n = 0;
      exp_t e;
      e.nm = name; e.st = st; e.val = rv; e.cnt = cnt;
      sb.push_back(e);
      req_op = op; req_key = k; req_value = v; req_valid = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clock);
         if (req_ready) acc = 1;
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      if (!acc) begin
         check({name, "_accept"}, 64'(0), 64'(1));
         sb.delete();
         return;
      end
      while (n < 60) begin
         @(negedge clock);
         n++;
         if (resp_valid) break;
      end
      check({name, "_latency"}, 64'(n), 64'(lat));
      @(posedge clock);
      #1;
      if (sb.size() != 0) sb.delete();
   endtask

   task automatic apply_reset(input string name);
      int n;
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check({name, "_rst_count"}, 64'(count), 64'(0));
      check({name, "_rst_ready"}, 64'(req_ready), 64'(0));
      check({name, "_rst_resp"}, 64'(resp_valid), 64'(0));
      req_op = SRCH; req_key = 32'h11; req_value = 32'h0; req_valid = 1'b1;
      reset_n = 1'b1;
      for (n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (req_ready) break;
      end
      check({name, "_ready_delay"}, 64'(n), 64'(16));
      check({name, "_post_count"}, 64'(count), 64'(0));
   endtask

   initial begin
      int seen0;
      reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_key = '0; req_value = '0;
      apply_reset("por");
      do_req("srch_empty", SRCH, 32'h11, 0, NF, 0, 0, 2);

      do_req("ins_11", INS, 32'h11, 100, OK, 100, 1, 2);
      do_req("ins_21", INS, 32'h21, 50, OK, 50, 2, 4);
      do_req("ins_31", INS, 32'h31, 7, OK, 7, 3, 4);
      do_req("srch_11", SRCH, 32'h11, 0, OK, 100, 3, 2);
      do_req("srch_21", SRCH, 32'h21, 0, OK, 50, 3, 2);
      do_req("srch_31", SRCH, 32'h31, 0, OK, 7, 3, 2);
      do_req("dup_21", INS, 32'h21, 99, DUP, 0, 3, 2);

      do_req("cred_11", CRED, 32'h11, 25, OK, 125, 3, 2);
      do_req("deb_under", DEB, 32'h11, 200, UNDER, 0, 3, 2);
      do_req("srch_11b", SRCH, 32'h11, 0, OK, 125, 3, 2);
      do_req("cred_over", CRED, 32'h31, 32'hFFFF_FFFF, OVER, 0, 3, 2);
      do_req("srch_31b", SRCH, 32'h31, 0, OK, 7, 3, 2);
      do_req("deb_21", DEB, 32'h21, 50, OK, 0, 3, 2);
      do_req("srch_21b", SRCH, 32'h21, 0, OK, 0, 3, 2);
      do_req("cred_miss", CRED, 32'h77, 1, NF, 0, 3, 2);

      // insert 0x41 collides at T1[1]; reset lands while it is in KICK1
      req_op = INS; req_key = 32'h41; req_value = 9; req_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (req_ready) break;
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(posedge clock);
      #1;
      seen0 = resp_seen;
      apply_reset("midkick");
      check("midkick_no_resp", 64'(resp_seen), 64'(seen0));
      do_req("post_srch_11", SRCH, 32'h11, 0, NF, 0, 0, 2);
      do_req("post_srch_21", SRCH, 32'h21, 0, NF, 0, 0, 2);
      do_req("post_srch_31", SRCH, 32'h31, 0, NF, 0, 0, 2);
      do_req("post_srch_41", SRCH, 32'h41, 0, NF, 0, 0, 2);

      do_req("ins_101", INS, 32'h101, 1, OK, 1, 1, 2);
      do_req("ins_201", INS, 32'h201, 2, OK, 2, 2, 4);
      do_req("ins_301", INS, 32'h301, 3, FULL, 0, 3, 13);
      do_req("srch_101", SRCH, 32'h101, 0, OK, 1, 3, 2);
      do_req("srch_201", SRCH, 32'h201, 0, OK, 2, 3, 2);
      do_req("srch_301", SRCH, 32'h301, 0, OK, 3, 3, 2);
      do_req("cred_stash", CRED, 32'h101, 5, OK, 6, 3, 2);
      do_req("srch_stash", SRCH, 32'h101, 0, OK, 6, 3, 2);
      do_req("ins_401", INS, 32'h401, 4, FULL, 0, 3, 2);
      do_req("ins_key0", INS, 32'h0, 5, BADK, 0, 3, 2);
      do_req("srch_key0", SRCH, 32'h0, 0, BADK, 0, 3, 2);

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
